// File: rtl/mux_81_rr.sv
// Round-robin 8-to-1 collector: grants one requesting channel at a time, presents its data
// bit with the channel index under valid/ready, pulses ack on acceptance, err on watchdog drop.
module mux_81_rr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] d,
    input  logic       out_ready,
    output logic       y,
    output logic [2:0] sel,
    output logic       valid,
    output logic [7:0] ack,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StSend, StAck} state_e;

    state_e     state_q;
    logic [2:0] ptr_q;
    logic [7:0] wdog_q;
    logic       y_q;
    logic [2:0] sel_q;
    logic       valid_q;
    logic [7:0] ack_q;
    logic       err_q;

    logic       grant_found;
    logic [2:0] grant_idx;
    logic [2:0] cand_idx;
    logic       wdog_expired;

    // Walk the search order backwards so the lowest offset from ptr_q is the last to win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        cand_idx    = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            cand_idx = ptr_q + 3'(i);
            if (req[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign wdog_expired = (TIMEOUT != 0) && (wdog_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            wdog_q  <= 8'd0;
            y_q     <= 1'b0;
            sel_q   <= 3'd0;
            valid_q <= 1'b0;
            ack_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 8'd0;
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        sel_q   <= grant_idx;
                        y_q     <= d[grant_idx];
                        valid_q <= 1'b1;
                        wdog_q  <= 8'd0;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= 8'd1 << sel_q;
                        ptr_q   <= sel_q + 3'd1;
                        state_q <= StAck;
                    end else if (wdog_expired) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                        ptr_q   <= sel_q + 3'd1;
                        state_q <= StAck;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign y     = y_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign ack   = ack_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mux_81_rr.sv
// Directed bench for mux_81_rr: three instances share stimulus with watchdog limits 15, 4 and 0.
module tb_mux_81_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'd0;
    logic [7:0] d = 8'd0;
    logic       out_ready = 1'b0;

    logic       y, y4, y0;
    logic [2:0] sel, sel4, sel0;
    logic       valid, valid4, valid0;
    logic [7:0] ack, ack4, ack0;
    logic       err, err4, err0;

    int checks = 0;
    int errors = 0;

    mux_81_rr #(.TIMEOUT(15)) u_dut (
        .clk(clk), .rst(rst), .req(req), .d(d), .out_ready(out_ready),
        .y(y), .sel(sel), .valid(valid), .ack(ack), .err(err)
    );

    mux_81_rr #(.TIMEOUT(4)) u_t4 (
        .clk(clk), .rst(rst), .req(req), .d(d), .out_ready(out_ready),
        .y(y4), .sel(sel4), .valid(valid4), .ack(ack4), .err(err4)
    );

    mux_81_rr #(.TIMEOUT(0)) u_t0 (
        .clk(clk), .rst(rst), .req(req), .d(d), .out_ready(out_ready),
        .y(y0), .sel(sel0), .valid(valid0), .ack(ack0), .err(err0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'd0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        d = 8'hFF;
        out_ready = 1'b1;
        step();
        checks++;
        if ({valid, sel, y, ack, err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {valid, sel, y, ack, err});
        end
        checks++;
        if ({valid4, sel4, y4, ack4, err4, valid0, sel0, y0, ack0, err0} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs_alt got %h want 0",
                     {valid4, sel4, y4, ack4, err4, valid0, sel0, y0, ack0, err0});
        end
        rst = 1'b0;
        req = 8'd0;
        d = 8'd0;
        out_ready = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h20;
        d = 8'h20;
        out_ready = 1'b1;
        step();
        checks++;
        if ({valid, sel, y, ack} !== {1'b1, 3'd5, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL single_grant got v=%b sel=%0d y=%b ack=%h want v=1 sel=5 y=1 ack=00",
                     valid, sel, y, ack);
        end
        step();
        checks++;
        if ({valid, ack, err} !== {1'b0, 8'h20, 1'b0}) begin
            errors++;
            $display("FAIL single_ack got v=%b ack=%h err=%b want v=0 ack=20 err=0",
                     valid, ack, err);
        end
        req = 8'h00;
        step();
        checks++;
        if ({valid, ack} !== 9'd0) begin
            errors++;
            $display("FAIL single_idle got v=%b ack=%h want v=0 ack=00", valid, ack);
        end
    endtask

    // Continues from test_single: ptr is 6, so channel 0 beats channel 5.
    task automatic test_rotation();
        req = 8'h21;
        d = 8'h01;
        step();
        checks++;
        if ({valid, sel, y} !== {1'b1, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL rot_first got v=%b sel=%0d y=%b want v=1 sel=0 y=1", valid, sel, y);
        end
        step();
        checks++;
        if (ack !== 8'h01) begin
            errors++;
            $display("FAIL rot_first_ack got %h want 01", ack);
        end
        req = 8'h20;
        step();
        step();
        checks++;
        if ({valid, sel, y} !== {1'b1, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL rot_second got v=%b sel=%0d y=%b want v=1 sel=5 y=0", valid, sel, y);
        end
        step();
        checks++;
        if (ack !== 8'h20) begin
            errors++;
            $display("FAIL rot_second_ack got %h want 20", ack);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_contention();
        logic [7:0] data;
        int         ch;
        data = 8'hA5;
        do_reset();
        req = 8'hFF;
        d = data;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            ch = k % 8;
            step();
            checks++;
            if ({valid, sel, y, ack} !== {1'b1, 3'(ch), data[ch], 8'h00}) begin
                errors++;
                $display("FAIL cont_grant%0d got v=%b sel=%0d y=%b ack=%h want v=1 sel=%0d y=%b",
                         k, valid, sel, y, ack, ch, data[ch]);
            end
            step();
            checks++;
            if ({valid, ack} !== {1'b0, 8'(1 << ch)}) begin
                errors++;
                $display("FAIL cont_ack%0d got v=%b ack=%h want v=0 ack=%h",
                         k, valid, ack, 8'(1 << ch));
            end
            step();
            checks++;
            if ({valid, ack, err} !== 10'd0) begin
                errors++;
                $display("FAIL cont_idle%0d got v=%b ack=%h err=%b want 0", k, valid, ack, err);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h08;
        d = 8'h08;
        out_ready = 1'b0;
        step();
        checks++;
        if ({valid, sel, y} !== {1'b1, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL bp_grant got v=%b sel=%0d y=%b want v=1 sel=3 y=1", valid, sel, y);
        end
        for (int k = 0; k < 6; k++) begin
            d = d ^ 8'h08;
            step();
            checks++;
            if ({valid, sel, y, ack, err} !== {1'b1, 3'd3, 1'b1, 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b sel=%0d y=%b ack=%h err=%b want v=1 sel=3 y=1",
                         k, valid, sel, y, ack, err);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({valid, ack} !== {1'b0, 8'h08}) begin
            errors++;
            $display("FAIL bp_ack got v=%b ack=%h want v=0 ack=08", valid, ack);
        end
        req = 8'h00;
        step();
        checks++;
        if (ack !== 8'h00) begin
            errors++;
            $display("FAIL bp_single_pulse got ack=%h want 00", ack);
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        req = 8'h04;
        d = 8'h00;
        out_ready = 1'b0;
        step();
        checks++;
        if ({valid4, sel4, valid0, sel0} !== {1'b1, 3'd2, 1'b1, 3'd2}) begin
            errors++;
            $display("FAIL to_grant got v4=%b sel4=%0d v0=%b sel0=%0d want 1 2 1 2",
                     valid4, sel4, valid0, sel0);
        end
        for (int k = 1; k < 4; k++) begin
            step();
            checks++;
            if ({valid4, err4} !== 2'b10) begin
                errors++;
                $display("FAIL to_wait%0d got v4=%b err4=%b want v4=1 err4=0", k, valid4, err4);
            end
        end
        step();
        checks++;
        if ({valid4, err4, ack4} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL to_err got v4=%b err4=%b ack4=%h want v4=0 err4=1 ack4=00",
                     valid4, err4, ack4);
        end
        req = 8'h0C;
        step();
        checks++;
        if ({err4, ack4} !== 9'd0) begin
            errors++;
            $display("FAIL to_err_pulse got err4=%b ack4=%h want 0", err4, ack4);
        end
        step();
        checks++;
        if ({valid4, sel4} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL to_ptr_advance got v4=%b sel4=%0d want v4=1 sel4=3", valid4, sel4);
        end
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (err0 !== 1'b0 || valid0 !== 1'b1 || ack0 !== 8'h00) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL to_disabled got %0d bad cycles want 0", bad);
        end
        req = 8'h00;
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        req = 8'h02;
        out_ready = 1'b1;
        d = 8'hFF;
        step();
        step();
        req = 8'h81;
        out_ready = 1'b0;
        step();
        step();
        checks++;
        if ({valid, sel, y} !== {1'b1, 3'd7, 1'b1}) begin
            errors++;
            $display("FAIL mid_grant got v=%b sel=%0d y=%b want v=1 sel=7 y=1", valid, sel, y);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if ({valid, sel, y, ack, err} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset got %h want 0", {valid, sel, y, ack, err});
        end
        rst = 1'b0;
        out_ready = 1'b0;
        step();
        checks++;
        if ({valid, sel, ack, err} !== {1'b1, 3'd0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mid_ptr_reset got v=%b sel=%0d ack=%h err=%b want v=1 sel=0 ack=00 err=0",
                     valid, sel, ack, err);
        end
        req = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got no finish want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
